// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller for the five-stage core.
// Merges ID/EX single-cycle stall requests with a multi-cycle EX hold engine,
// applies the flush override and keeps a saturating count of stalled cycles.
module pipe_stall_ctrl #(
   parameter int CNT_WIDTH  = 6,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallreq_from_id,
   input  logic                  stallreq_from_ex,
   input  logic                  ex_multi_start,
   input  logic [CNT_WIDTH-1:0]  ex_multi_cycles,
   input  logic                  flush,
   output logic [5:0]            stall,
   output logic                  multi_busy_o,
   output logic                  multi_done_o,
   output logic [STAT_WIDTH-1:0] stall_cycles_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // PC, IF, ID, EX held; MEM/WB keep draining.
   localparam logic [5:0] STALL_EX   = 6'b001111;
   // PC, IF, ID held; the bubble enters EX.
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_NONE = 6'b000000;

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [STAT_WIDTH-1:0]   stat_q;
   logic                    accept;

   // A start is only taken while the engine is idle and no flush is pending.
   assign accept = ex_multi_start & (state_q == IDLE) & ~flush;

   // Engine state and hold counter; asynchronous reset returns to IDLE at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: flush aborts any operation without a done pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (ex_multi_cycles != '0) begin
                     state_d = BUSY;
                     cnt_d   = ex_multi_cycles;
                  end else begin
                     state_d = DONE;
                     cnt_d   = '0;
                  end
               end
            end
            BUSY: begin
               // Counter holds the number of BUSY cycles still to go, this one included.
               if (cnt_q <= CNT_ONE) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            DONE: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Stall vector by priority: flush, then EX-side hold, then ID load-use.
   always_comb begin
      stall = STALL_NONE;
      if (flush) begin
         stall = STALL_NONE;
      end else if (accept || (state_q == BUSY) || stallreq_from_ex) begin
         stall = STALL_EX;
      end else if (stallreq_from_id) begin
         stall = STALL_ID;
      end
   end

   // Saturating count of cycles in which any stage was stopped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else if ((stall != STALL_NONE) && (stat_q != STAT_MAX)) begin
         stat_q <= stat_q + STAT_WIDTH'(1);
      end
   end

   assign multi_busy_o   = (state_q == BUSY);
   assign multi_done_o   = (state_q == DONE) & ~flush;
   assign stall_cycles_o = stat_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboarded bench for pipe_stall_ctrl: a driver issues one input set per
// cycle and queues the outputs a timeline model predicts; a monitor pops and
// compares on the falling edge.
module tb_pipe_stall_ctrl;

   localparam int CNT_WIDTH  = 6;
   localparam int STAT_WIDTH = 16;
   localparam int STAT_MAX   = (1 << STAT_WIDTH) - 1;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  stallreq_from_id = 1'b0;
   logic                  stallreq_from_ex = 1'b0;
   logic                  ex_multi_start = 1'b0;
   logic [CNT_WIDTH-1:0]  ex_multi_cycles = '0;
   logic                  flush = 1'b0;
   logic [5:0]            stall;
   logic                  multi_busy_o;
   logic                  multi_done_o;
   logic [STAT_WIDTH-1:0] stall_cycles_o;

   pipe_stall_ctrl #(.CNT_WIDTH(CNT_WIDTH), .STAT_WIDTH(STAT_WIDTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .stallreq_from_id (stallreq_from_id),
      .stallreq_from_ex (stallreq_from_ex),
      .ex_multi_start   (ex_multi_start),
      .ex_multi_cycles  (ex_multi_cycles),
      .flush            (flush),
      .stall            (stall),
      .multi_busy_o     (multi_busy_o),
      .multi_done_o     (multi_done_o),
      .stall_cycles_o   (stall_cycles_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [5:0] stall;
      logic       busy;
      logic       done;
      int         stat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   verbose = 1'b1;

   // Timeline model: an accepted op at cycle t with length n is busy in
   // t+1..t+n and presents its result in t+n+1; flush discards it.
   int cyc;
   bit op_act;
   int op_t;
   int op_n;
   int stat_m;

   function automatic void model_reset();
      cyc    = 0;
      op_act = 1'b0;
      op_t   = 0;
      op_n   = 0;
      stat_m = 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus: apply inputs just after the edge, queue the prediction.
   task automatic drive(input bit id, input bit ex, input bit start,
                        input int n, input bit fl);
      exp_t e;
      bit   busy_now, done_slot, accept;
      @(posedge clk);
      #1;
      stallreq_from_id = id;
      stallreq_from_ex = ex;
      ex_multi_start   = start;
      ex_multi_cycles  = CNT_WIDTH'(n);
      flush            = fl;

      busy_now  = op_act && (cyc > op_t) && (cyc <= op_t + op_n);
      done_slot = op_act && (cyc == op_t + op_n + 1);
      accept    = start && !op_act && !fl;

      e.cyc  = cyc;
      e.busy = busy_now;
      e.done = done_slot && !fl;
      e.stat = stat_m;
      if (fl)                             e.stall = 6'b000000;
      else if (accept || busy_now || ex)  e.stall = 6'b001111;
      else if (id)                        e.stall = 6'b000111;
      else                                e.stall = 6'b000000;
      sb.push_back(e);

      if (fl)             op_act = 1'b0;
      else if (accept)    begin op_act = 1'b1; op_t = cyc; op_n = n; end
      else if (done_slot) op_act = 1'b0;
      if (e.stall != 6'b000000 && stat_m < STAT_MAX) stat_m++;
      cyc++;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
   endtask

   // Monitor: compares every queued prediction against the DUT mid-cycle.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (verbose)
               $display("cyc %0d: stall=%b busy=%b done=%b stat=%0d (exp %b %b %b %0d)",
                        e.cyc, stall, multi_busy_o, multi_done_o, stall_cycles_o,
                        e.stall, e.busy, e.done, e.stat);
            check("stall", int'(stall), int'(e.stall));
            check("multi_busy_o", int'(multi_busy_o), int'(e.busy));
            check("multi_done_o", int'(multi_done_o), int'(e.done));
            check("stall_cycles_o", int'(stall_cycles_o), e.stat);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      model_reset();
      // Reset state while rst is held.
      #12;
      check("reset_stall", int'(stall), 0);
      check("reset_busy", int'(multi_busy_o), 0);
      check("reset_done", int'(multi_done_o), 0);
      check("reset_stat", int'(stall_cycles_o), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Idle after reset.
      idle(5);
      // ID requests, then EX requests.
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0);
      idle(2);
      // N = 4 operation, with an ID request during BUSY.
      drive(0, 0, 1, 4, 0);
      drive(1, 0, 0, 0, 0);
      idle(6);
      // N = 0 operation, then N = 3 with an ignored N = 8 start during BUSY.
      drive(0, 0, 1, 0, 0);
      idle(3);
      drive(0, 0, 1, 3, 0);
      drive(0, 0, 1, 8, 0);
      idle(6);
      // N = 10 aborted by flush at t+3, new start at t+5.
      drive(0, 0, 1, 10, 0);
      idle(2);
      drive(0, 1, 0, 0, 1);
      idle(1);
      drive(0, 0, 1, 2, 0);
      idle(5);
      // Flush colliding with a start; start during DONE is ignored.
      drive(0, 0, 1, 5, 1);
      drive(0, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 7, 0);
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
               $urandom_range(0, 99) < 15, int'($urandom_range(0, 12)),
               $urandom_range(0, 99) < 4);

      // Saturation of the statistics counter.
      verbose = 1'b0;
      for (int i = 0; i < 65540; i++) drive(0, 1, 0, 0, 0);
      idle(2);
      verbose = 1'b1;

      // Enter BUSY, then reset asynchronously mid-cycle.
      drive(0, 0, 1, 10, 0);
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      check("pre_reset_busy", int'(multi_busy_o), 1);
      check("pre_reset_stat", int'(stall_cycles_o), STAT_MAX);
      rst = 1'b1;
      #1;
      $display("async reset: stall=%b busy=%b done=%b stat=%0d",
               stall, multi_busy_o, multi_done_o, stall_cycles_o);
      check("async_rst_stall", int'(stall), 0);
      check("async_rst_busy", int'(multi_busy_o), 0);
      check("async_rst_done", int'(multi_done_o), 0);
      check("async_rst_stat", int'(stall_cycles_o), 0);
      @(posedge clk);
      #1;
      stallreq_from_id = 1'b0;
      stallreq_from_ex = 1'b0;
      ex_multi_start   = 1'b0;
      flush            = 1'b0;
      rst              = 1'b0;
      model_reset();
      // No done pulse after reset release.
      idle(12);
      @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline-control block for the five-stage OpenMIPS core.
- Produces the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Merges single-cycle stall requests from ID and EX with a sequential engine that holds the pipeline during multi-cycle EX operations (multiply-accumulate, divide).
- Also provides a flush override and a saturating stall-cycle statistics counter.

Parameters:
- CNT_WIDTH, 6, width of the multi-cycle length input and its internal down-counter.
- STAT_WIDTH, 16, width of the stall-cycle statistics counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high (`RstEnable = 1'b1).
- stallreq_from_id  input  1  ID-stage request (load-use hazard); combinational, level.
- stallreq_from_ex  input  1  EX-stage single-cycle request; combinational, level.
- ex_multi_start  input  1  one-cycle pulse: EX begins a multi-cycle operation.
- ex_multi_cycles  input  CNT_WIDTH  extra hold cycles N; sampled only when a start is accepted.
- flush  input  1  exception/flush; overrides everything and aborts the engine.
- stall  output  6  stall vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB; 1 = `Stop.
- multi_busy_o  output  1  engine in BUSY state.
- multi_done_o  output  1  one-cycle pulse: multi-cycle result may be committed this cycle.
- stall_cycles_o  output  STAT_WIDTH  count of cycles with stall != 0.

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - state = IDLE, counter = 0, stall_cycles_o = 0.
  - Hence stall = 6'b000000, multi_busy_o = 0, multi_done_o = 0.
- Engine states: IDLE, BUSY, DONE (registered).
- Start acceptance:
  - accept = ex_multi_start & (state == IDLE) & ~flush.
  - A start in BUSY or DONE is ignored.
- Transitions:
  - IDLE: accept and N > 0 -> BUSY, counter <= N. Accept and N == 0 -> DONE.
  - BUSY: counter decrements each cycle. When counter == 1, next state is DONE (counter <= 0).
  - DONE: -> IDLE unconditionally after one cycle.
  - flush in any state -> IDLE and counter <= 0 next edge. No multi_done_o pulse is generated for the aborted operation.
- Outputs:
  - multi_busy_o = (state == BUSY).
  - multi_done_o = (state == DONE) & ~flush.
- Timing for a start accepted in cycle t with length N:
  - stall held 6'b001111 in cycles t .. t+N.
  - Cycle t+N+1: state DONE, multi_done_o = 1, stall released (unless other requests are active).
  - N == 0 therefore stalls for exactly cycle t.
- Stall vector (combinational), priority highest first:
  1. flush -> 6'b000000.
  2. accept | (state == BUSY) | stallreq_from_ex -> 6'b001111 (PC, IF, ID, EX held; MEM/WB drain).
  3. stallreq_from_id -> 6'b000111.
  4. Otherwise 6'b000000.
- stallreq_from_ex and stallreq_from_id have no effect on engine state.
- Statistics counter:
  - Increments on each rising edge where stall != 0.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset asserted mid-BUSY: engine returns to IDLE immediately; no done pulse after reset release.
- Simultaneous events:
  - flush and start in the same cycle: start is not accepted.
  - stallreq_from_id during BUSY: vector stays 6'b001111 (EX request dominates).
- Output sanity: no X on any output after reset; stall bits above [5] do not exist.

Test Plan:
- Reset, then idle 5 cycles -> stall = 000000, multi_busy_o = 0, multi_done_o = 0, stall_cycles_o = 0.
- stallreq_from_id = 1 for 3 cycles, then stallreq_from_ex = 1 for 2 cycles -> stall = 000111 x3, then 001111 x2; stall_cycles_o = 5.
- ex_multi_start at cycle t with ex_multi_cycles = 4 -> stall = 001111 in t..t+4, multi_busy_o = 1 in t+1..t+4, multi_done_o = 1 only in t+5, stall = 000000 at t+5.
- ex_multi_cycles = 0 start -> stall only in t, multi_done_o in t+1; a second start pulse during BUSY (N = 8) is ignored, so total stall matches the first op only.
- Start with N = 10, flush asserted at t+3 -> stall = 000000 at t+3, IDLE at t+4, no multi_done_o ever; a new start at t+5 is accepted.
- Preload by holding stallreq_from_ex for 65540 cycles (STAT_WIDTH = 16) -> stall_cycles_o saturates at 16'hFFFF. Then assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge.
